// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-I subset core with req/ack instruction and data memory ports.
// Supports R-type add/sub/and/or/slt, addi/andi/ori, lw/sw, beq/bne, j, and a sticky halt/trap.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_FETCH  | imem_req high, wait for imem_ack, latch IR
//  S_DECODE | read rs/rt into A/B, build immediate, trap illegal or halt op
//  S_EXEC   | ALU / address calc; branches and jumps retire here
//  S_MEM    | dmem_req held until dmem_ack; sw retires here
//  S_WB     | register write-back, pc += 4, retire
//  S_HALT   | stopped until reset
module mips_multicycle_core #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'h3F
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir, a, b, imm, alu_out, mdr;
    logic [31:0]       rf [32];

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd, dest;
    logic              legal, taken;
    logic [31:0]       ext_imm, alu_res, off32, pc4_32, j32;
    logic [ADDR_W-1:0] pc_plus4, br_target, j_target;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign dest  = (op == OP_RTYPE) ? rd : rt;

    assign ext_imm = (op == OP_ANDI || op == OP_ORI) ? {16'h0000, ir[15:0]}
                                                     : {{16{ir[15]}}, ir[15:0]};
    assign taken   = (op == OP_BEQ) ? (a == b) : (a != b);

    assign pc_plus4  = pc + ADDR_W'(4);
    assign off32     = {imm[29:0], 2'b00};
    assign br_target = pc_plus4 + off32[ADDR_W-1:0];
    assign pc4_32    = 32'(pc_plus4);
    assign j32       = {pc4_32[31:28], ir[25:0], 2'b00};
    assign j_target  = j32[ADDR_W-1:0];

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
            OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
            OP_BEQ, OP_BNE, OP_J: legal = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_res = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_res = a + b;
                    F_SUB:   alu_res = a - b;
                    F_AND:   alu_res = a & b;
                    F_OR:    alu_res = a | b;
                    F_SLT:   alu_res = {31'b0, ($signed(a) < $signed(b))};
                    default: alu_res = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: alu_res = a + imm;
            OP_ANDI:               alu_res = a & imm;
            OP_ORI:                alu_res = a | imm;
            default:               alu_res = '0;
        endcase
    end

    // Gated by rst so the fetch request is low while reset is held, yet the
    // first fetch after release starts without an idle cycle.
    assign imem_req   = (state == S_FETCH) && rst;
    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = alu_out[ADDR_W-1:0];
    assign dmem_wdata = b;
    assign retire     = (state == S_WB)
                     || (state == S_EXEC && (op == OP_BEQ || op == OP_BNE || op == OP_J))
                     || (state == S_MEM && dmem_ack && op == OP_SW);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            imm      <= '0;
            alu_out  <= '0;
            mdr      <= '0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a   <= rf[rs];
                    b   <= rf[rt];
                    imm <= ext_imm;
                    if (op == HALT_OP) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (!legal) begin
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_out <= alu_res;
                    case (op)
                        OP_BEQ, OP_BNE: begin
                            pc    <= taken ? br_target : pc_plus4;
                            state <= S_FETCH;
                        end
                        OP_J: begin
                            pc    <= j_target;
                            state <= S_FETCH;
                        end
                        OP_LW, OP_SW: begin
                            if (alu_res[1:0] != 2'b00) begin
                                halted  <= 1'b1;
                                illegal <= 1'b1;
                                state   <= S_HALT;
                            end else begin
                                dmem_req <= 1'b1;
                                dmem_we  <= (op == OP_SW);
                                state    <= S_MEM;
                            end
                        end
                        default: state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (op == OP_SW) begin
                            pc    <= pc_plus4;
                            state <= S_FETCH;
                        end else begin
                            mdr   <= dmem_rdata;
                            state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (dest != 5'd0) rf[dest] <= (op == OP_LW) ? mdr : alu_out;
                    pc    <= pc_plus4;
                    state <= S_FETCH;
                end
                S_HALT: ;
                default: state <= S_HALT;
            endcase
        end
    end

endmodule
